// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch/decode/exec/mem/wb,
// handshakes with the shared memory port and drives all datapath enables and mux selects.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             bus_fault,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StBrj    = 3'd6,
    StHalt   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsR, ClsI, ClsBr, ClsJ, ClsLd, ClsSt, ClsIll
  } cls_e;

  localparam int unsigned WaitW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn   = (MEM_TIMEOUT != 0);
  localparam int unsigned TimeoutLast = TimeoutEn ? MEM_TIMEOUT - 1 : 0;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             bf_q, bf_d;
  logic             retire;
  logic             timeout;

  always_comb begin
    dec_cls = ClsIll;
    casez (opcode)
      6'b000000: dec_cls = ClsR;
      6'b001???: dec_cls = ClsI;
      6'b0001??: dec_cls = ClsBr;
      6'b00001?: dec_cls = ClsJ;
      6'b100???: dec_cls = ClsLd;
      6'b101???: dec_cls = ClsSt;
      default:   dec_cls = ClsIll;
    endcase
  end

  // The current cycle is the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = TimeoutEn && (wait_q == WaitW'(TimeoutLast));

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    wait_d        = '0;
    ill_d         = ill_q;
    bf_d          = bf_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          bf_d    = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        alu_src_b = 2'b10;
        cls_d     = dec_cls;
        unique case (dec_cls)
          ClsR, ClsI, ClsLd, ClsSt: state_d = StExec;
          ClsBr, ClsJ:              state_d = StBrj;
          default: begin
            ill_d   = 1'b1;
            state_d = StHalt;
          end
        endcase
      end
      StExec: begin
        unique case (cls_q)
          ClsR: begin
            alu_op  = 2'b10;
            state_d = StWb;
          end
          ClsI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = StWb;
          end
          ClsLd, ClsSt: begin
            alu_src_b = 2'b10;
            state_d   = StMem;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == ClsSt);
        if (mem_ready) begin
          if (cls_q == ClsLd) state_d = StWb;
          else                retire  = 1'b1;
        end else if (timeout) begin
          bf_d    = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == ClsR);
        mem_to_reg = (cls_q == ClsLd);
        retire     = 1'b1;
      end
      StBrj: begin
        if (cls_q == ClsBr) begin
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end else begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        retire = 1'b1;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StHalt;
    endcase

    if (retire) state_d = run ? StFetch : StIdle;
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cls_q   <= ClsNone;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      bf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      bf_q    <= bf_d;
    end
  end

  assign illegal_op  = ill_q;
  assign bus_fault   = bf_q;
  assign retired_cnt = cnt_q;
  assign state_o     = state_q;

endmodule
